// File: rtl/nn_inference_ctrl.sv
// Sequences one feature vector through N_STAGES one-hot stage enables and captures the class result.
// Latency: accept edge E0 -> res_valid on edge E0+N_STAGES*STAGE_LAT; all outputs registered.
// Backpressure: in_ready low from accept until pop/abort; result held until res_ready, abort overrides.
module nn_inference_ctrl #(
  parameter int IN_SIZE   = 40,
  parameter int N_STAGES  = 5,
  parameter int STAGE_LAT = 2,
  parameter int CNT_W     = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [IN_SIZE-1:0][7:0]   in_data,
  output logic [IN_SIZE-1:0][7:0]   nn_input_vector,
  output logic [N_STAGES-1:0]       stage_en,
  input  logic [1:0]                nn_output_value,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [1:0]                res_class,
  input  logic                      abort,
  output logic                      busy,
  output logic [CNT_W-1:0]          infer_count
);

  localparam int SW = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
  localparam int CW = (STAGE_LAT > 1) ? $clog2(STAGE_LAT) : 1;
  localparam logic [SW-1:0] LAST_STAGE = SW'(N_STAGES - 1);
  localparam logic [CW-1:0] CNT_RELOAD = CW'(STAGE_LAT - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                    state, state_nx;
  logic [SW-1:0]             stage, stage_nx;
  logic [CW-1:0]             cnt, cnt_nx;
  logic                      in_ready_nx;
  logic [IN_SIZE-1:0][7:0]   vec_nx;
  logic [N_STAGES-1:0]       stage_en_nx;
  logic                      res_valid_nx;
  logic [1:0]                res_class_nx;
  logic                      busy_nx;
  logic [CNT_W-1:0]          infer_count_nx;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= IDLE;
      stage           <= '0;
      cnt             <= '0;
      in_ready        <= 1'b0;
      nn_input_vector <= '0;
      stage_en        <= '0;
      res_valid       <= 1'b0;
      res_class       <= 2'd0;
      busy            <= 1'b0;
      infer_count     <= '0;
    end else begin
      state           <= state_nx;
      stage           <= stage_nx;
      cnt             <= cnt_nx;
      in_ready        <= in_ready_nx;
      nn_input_vector <= vec_nx;
      stage_en        <= stage_en_nx;
      res_valid       <= res_valid_nx;
      res_class       <= res_class_nx;
      busy            <= busy_nx;
      infer_count     <= infer_count_nx;
    end
  end

  always_comb begin
    state_nx       = state;
    stage_nx       = stage;
    cnt_nx         = cnt;
    in_ready_nx    = in_ready;
    vec_nx         = nn_input_vector;
    stage_en_nx    = stage_en;
    res_valid_nx   = res_valid;
    res_class_nx   = res_class;
    busy_nx        = busy;
    infer_count_nx = infer_count;

    case (state)
      IDLE: begin
        // in_ready is registered, so the first edge out of reset only raises it
        in_ready_nx = 1'b1;
        if (in_valid && in_ready) begin
          vec_nx      = in_data;
          in_ready_nx = 1'b0;
          busy_nx     = 1'b1;
          stage_nx    = '0;
          cnt_nx      = CNT_RELOAD;
          stage_en_nx = N_STAGES'(1);
          state_nx    = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_nx    = IDLE;
          stage_en_nx = '0;
          res_valid_nx = 1'b0;
          busy_nx     = 1'b0;
          in_ready_nx = 1'b1;
        end else if (cnt != '0) begin
          cnt_nx = cnt - 1'b1;
        end else if (stage != LAST_STAGE) begin
          stage_nx    = stage + 1'b1;
          cnt_nx      = CNT_RELOAD;
          stage_en_nx = stage_en << 1;
        end else begin
          // final stage is still enabled this cycle, so its output is valid now
          res_class_nx = nn_output_value;
          stage_en_nx  = '0;
          res_valid_nx = 1'b1;
          state_nx     = DONE;
        end
      end
      DONE: begin
        if (abort) begin
          state_nx     = IDLE;
          stage_en_nx  = '0;
          res_valid_nx = 1'b0;
          busy_nx      = 1'b0;
          in_ready_nx  = 1'b1;
        end else if (res_ready) begin
          res_valid_nx   = 1'b0;
          busy_nx        = 1'b0;
          infer_count_nx = infer_count + 1'b1;
          in_ready_nx    = 1'b1;
          state_nx       = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: doc/nn_inference_ctrl.md
Name: nn_inference_ctrl

Overview:
- Sequencing controller for the speech-recognition neural-network pipeline (4 dense layers with their dropout layers, then the final layer).
- Accepts one feature vector per inference over a valid/ready handshake and holds it stable on the network input.
- Steps a one-hot stage enable through the pipeline stages, allowing a fixed number of cycles per stage, then captures the 2-bit class result.
- Presents the result over a valid/ready handshake and counts completed inferences.

Parameters:
- IN_SIZE, 40: number of signed 8-bit input features.
- N_STAGES, 5: number of sequenced stages (4 dense + final); must be >= 1.
- STAGE_LAT, 2: cycles allotted per stage; must be >= 1.
- CNT_W, 16: width of the completed-inference counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-low (rst==0 resets on the clock edge).
- in_valid  in  1  feature vector offered.
- in_ready  out  1  controller can accept a vector.
- in_data  in  IN_SIZE x 8 signed  offered feature vector.
- nn_input_vector  out  IN_SIZE x 8 signed  latched vector driven to the network.
- stage_en  out  N_STAGES  one-hot enable of the active stage; bit 0 is dense layer 1.
- nn_output_value  in  2  class output from the final layer.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_class  out  2  captured class.
- abort  in  1  cancel the inference in progress.
- busy  out  1  high in RUN or DONE.
- infer_count  out  CNT_W  count of completed (popped) inferences.

Behaviour:
- Reset and output timing:
  - All outputs are registered.
  - While rst==0: state=IDLE, in_ready=0, nn_input_vector=all 0, stage_en=0, res_valid=0, res_class=0, busy=0, infer_count=0, stage=0, cnt=0.
  - First edge with rst==1 sets in_ready=1.
  - Reset mid-operation discards everything, with no result and no count.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On the edge with in_valid && in_ready (E0): latch in_data into nn_input_vector; in_ready<=0; busy<=1; stage<=0; cnt<=STAGE_LAT-1; stage_en<=1; go to RUN.
  - in_data changes while not accepted have no effect.
- RUN:
  - stage_en = 1<<stage, and exactly one bit is high.
  - Each edge: if cnt!=0, cnt--.
  - When cnt==0 and stage<N_STAGES-1: stage++, cnt<=STAGE_LAT-1, and stage_en shifts left on the same edge.
  - When cnt==0 and stage==N_STAGES-1: res_class<=nn_output_value; stage_en<=0; res_valid<=1; go to DONE.
  - nn_input_vector is held constant throughout RUN and DONE.
- Latency:
  - stage_en bit k is high for the cycles after edges E0+k*STAGE_LAT .. E0+(k+1)*STAGE_LAT-1.
  - res_valid rises on edge E0+N_STAGES*STAGE_LAT (edge E0+10 with defaults).
  - The class is sampled on that same edge, during the last cycle of the final stage.
- DONE:
  - res_valid and res_class are held until res_ready is sampled high.
  - On that edge: res_valid<=0; busy<=0; infer_count++ (wraps modulo 2^CNT_W, all-ones -> 0); in_ready<=1; go to IDLE.
  - A new vector cannot be accepted on the pop edge; the earliest accept is the following edge.
- abort:
  - Sampled in RUN or DONE; it has priority over res_ready and over stage advance.
  - Next edge: state=IDLE, stage_en=0, res_valid=0, busy=0, in_ready=1. res_class keeps its last value, and infer_count is unchanged.
  - abort in IDLE is ignored, and a simultaneous in_valid is still accepted.
- STAGE_LAT=1: each stage is enabled for exactly one cycle, with no idle gap between stages.

Test Plan:
- Reset/release: hold rst=0 for 3 cycles with in_valid=1 -> all outputs 0, no accept; after release, in_ready=1 exactly one edge later.
- Single inference, defaults: accept vector (in_data[0]=-5, in_data[39]=127), nn_output_value=2'd3 -> stage_en sequence 00001,00001,00010,00010,…,10000,10000; res_valid on edge E0+10 with res_class=3; res_ready=1 -> infer_count=1, in_ready=1 next cycle.
- Back-pressure: res_ready held 0 for 20 cycles while nn_output_value toggles -> res_class stays at the captured value, in_ready=0, in_valid ignored; then pop -> count increments by 1.
- Abort: assert abort during stage 2 -> next cycle stage_en=0, busy=0, in_ready=1, no res_valid; abort together with res_ready in DONE -> infer_count unchanged.
- Back-to-back plus wrap: CNT_W=2, run 5 inferences with in_valid and res_ready tied high -> accepts exactly 12 cycles apart with defaults (E0 → res_valid at E0+10, pop at E0+11, next accept at E0+12); infer_count sequence 1,2,3,0,1.
- STAGE_LAT=1, N_STAGES=5: res_valid on edge E0+5, and each stage_en bit is high for exactly one cycle.
